// File: rtl/vending_pkg.sv
// Shared types and constants for the multi-product vending controller.
package vending_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_VEND,
    ST_CHANGE,
    ST_ALARM
  } state_e;

  localparam logic [1:0] ALARM_NONE    = 2'd0;
  localparam logic [1:0] ALARM_CREDIT  = 2'd1;
  localparam logic [1:0] ALARM_SOLDOUT = 2'd2;
  localparam logic [1:0] ALARM_TIMEOUT = 2'd3;

  localparam int COIN_HI_DEF = 5;

endpackage

// File: rtl/vend_change_dispenser.sv
// Change emitter: load an amount, then one coin pulse per cycle until empty.
// High-denomination coins go first, then 1-unit coins.
module vend_change_dispenser #(
  parameter int AMT_W   = 8,
  parameter int COIN_HI = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [AMT_W-1:0] amt_i,
  input  logic             abort_i,
  output logic             pulse_o,
  output logic             hi_o,
  output logic             busy_o
);

  localparam logic [AMT_W-1:0] HI_AMT = AMT_W'(COIN_HI);

  logic [AMT_W-1:0] rem_q, rem_d;

  // Next remainder: abort clears, load replaces, otherwise pay out one coin.
  always_comb begin
    rem_d = rem_q;
    if (abort_i) begin
      rem_d = '0;
    end else if (load_i) begin
      rem_d = amt_i;
    end else if (rem_q >= HI_AMT) begin
      rem_d = rem_q - HI_AMT;
    end else if (rem_q != '0) begin
      rem_d = rem_q - 1'b1;
    end
  end

  // Remainder register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rem_q <= '0;
    else     rem_q <= rem_d;
  end

  assign busy_o  = (rem_q != '0);
  assign pulse_o = busy_o && !abort_i;
  assign hi_o    = pulse_o && (rem_q >= HI_AMT);

endmodule

// File: rtl/vending_ctrl_multi.sv
// Multi-product vending controller: credit collection, vend, change, alarms.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no transaction; first coin starts one
// ST_COLLECT | accumulating credit, waiting for confirm/cancel/timeout
// ST_VEND    | one-cycle dispense, stock/sales update
// ST_CHANGE  | dispenser paying out change_total
// ST_ALARM   | one-cycle alarm, credit cleared, then refund via ST_CHANGE
module vending_ctrl_multi
  import vending_pkg::*;
#(
  parameter int AMT_W       = 8,
  parameter int N_PROD      = 4,
  parameter int STOCK_W     = 4,
  parameter int SALES_W     = 16,
  parameter int COIN_HI     = COIN_HI_DEF,
  parameter int TIMEOUT_CYC = 1000,
  localparam int SEL_W      = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    coin_valid,
  input  logic [AMT_W-1:0]        coin_value,
  input  logic [SEL_W-1:0]        product_sel,
  input  logic                    confirm,
  input  logic                    cancel,
  input  logic [N_PROD*AMT_W-1:0] price_table,
  input  logic                    restock,
  input  logic [SEL_W-1:0]        restock_sel,
  input  logic                    sales_clr,
  input  logic                    service_mode,
  output logic [AMT_W-1:0]        coin_total,
  output logic                    coin_reject,
  output logic                    product_dispensed,
  output logic [SEL_W-1:0]        dispensed_sel,
  output logic                    change_pulse,
  output logic                    change_hi,
  output logic [AMT_W-1:0]        change_total,
  output logic                    alarm,
  output logic [1:0]              alarm_code,
  output logic                    busy,
  output logic [N_PROD-1:0]       sold_out,
  output logic [SALES_W-1:0]      total_sales
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

  state_e             state_q, state_d;
  logic [AMT_W-1:0]   credit_q, credit_d;
  logic [AMT_W-1:0]   change_total_q, change_total_d;
  logic [1:0]         alarm_code_q, alarm_code_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [AMT_W-1:0]   price_q, price_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               coin_reject_q, coin_reject_d;
  logic [SALES_W-1:0] total_sales_q, total_sales_d;
  logic [STOCK_W-1:0] stock_q [N_PROD];
  logic [AMT_W-1:0]   price_a [N_PROD];

  logic [AMT_W:0]     coin_sum;
  logic               coin_ovf;
  logic [AMT_W-1:0]   eff_credit;
  logic               vend_dec;
  logic               disp_load, disp_busy;

  for (genvar g = 0; g < N_PROD; g++) begin : g_slot
    assign price_a[g]  = price_table[g*AMT_W +: AMT_W];
    assign sold_out[g] = (stock_q[g] == '0);
  end

  // A coin arriving with confirm is counted before the credit check.
  assign coin_sum   = {1'b0, credit_q} + {1'b0, coin_value};
  assign coin_ovf   = coin_sum[AMT_W];
  assign eff_credit = (coin_valid && !coin_ovf) ? coin_sum[AMT_W-1:0] : credit_q;

  // Next-state and datapath control.
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    change_total_d = change_total_q;
    alarm_code_d   = alarm_code_q;
    sel_d          = sel_q;
    price_d        = price_q;
    tmo_d          = tmo_q;
    coin_reject_d  = 1'b0;
    total_sales_d  = total_sales_q;
    vend_dec       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (coin_valid) begin
          credit_d     = coin_value;
          alarm_code_d = ALARM_NONE;
          tmo_d        = TMO_LOAD;
          state_d      = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        credit_d      = eff_credit;
        coin_reject_d = coin_valid && coin_ovf;
        if (coin_valid || confirm || cancel) tmo_d = TMO_LOAD;
        else if (tmo_q != '0)                tmo_d = tmo_q - 1'b1;

        if (cancel) begin
          change_total_d = eff_credit;
          credit_d       = '0;
          state_d        = ST_CHANGE;
        end else if (confirm) begin
          sel_d   = product_sel;
          price_d = price_a[product_sel];
          if (stock_q[product_sel] == '0) begin
            alarm_code_d   = ALARM_SOLDOUT;
            change_total_d = eff_credit;
            state_d        = ST_ALARM;
          end else if (eff_credit < price_a[product_sel]) begin
            alarm_code_d   = ALARM_CREDIT;
            change_total_d = eff_credit;
            state_d        = ST_ALARM;
          end else begin
            change_total_d = eff_credit - price_a[product_sel];
            state_d        = ST_VEND;
          end
        end else if (!coin_valid && tmo_q == '0) begin
          alarm_code_d   = ALARM_TIMEOUT;
          change_total_d = credit_q;
          state_d        = ST_ALARM;
        end
      end
      ST_VEND: begin
        coin_reject_d = coin_valid;
        credit_d      = '0;
        total_sales_d = total_sales_q + SALES_W'(price_q);
        vend_dec      = 1'b1;
        state_d       = ST_CHANGE;
      end
      ST_CHANGE: begin
        coin_reject_d = coin_valid;
        if (!disp_busy) state_d = ST_IDLE;
      end
      ST_ALARM: begin
        coin_reject_d = coin_valid;
        credit_d      = '0;
        state_d       = ST_CHANGE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (sales_clr) total_sales_d = '0;

    if (service_mode) begin
      state_d        = ST_IDLE;
      credit_d       = '0;
      change_total_d = '0;
      total_sales_d  = '0;
      alarm_code_d   = ALARM_NONE;
      tmo_d          = '0;
      coin_reject_d  = 1'b0;
      vend_dec       = 1'b0;
    end
  end

  // Load the dispenser on every entry into ST_CHANGE.
  assign disp_load = (state_d == ST_CHANGE) && (state_q != ST_CHANGE);

  // Control and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      credit_q       <= '0;
      change_total_q <= '0;
      alarm_code_q   <= ALARM_NONE;
      sel_q          <= '0;
      price_q        <= '0;
      tmo_q          <= '0;
      coin_reject_q  <= 1'b0;
      total_sales_q  <= '0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      change_total_q <= change_total_d;
      alarm_code_q   <= alarm_code_d;
      sel_q          <= sel_d;
      price_q        <= price_d;
      tmo_q          <= tmo_d;
      coin_reject_q  <= coin_reject_d;
      total_sales_q  <= total_sales_d;
    end
  end

  // Per-slot stock; restock beats a same-slot vend decrement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_PROD; i++) stock_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_PROD; i++) begin
        if (restock && restock_sel == SEL_W'(i))
          stock_q[i] <= '1;
        else if (vend_dec && sel_q == SEL_W'(i) && stock_q[i] != '0)
          stock_q[i] <= stock_q[i] - 1'b1;
      end
    end
  end

  vend_change_dispenser #(
    .AMT_W  (AMT_W),
    .COIN_HI(COIN_HI)
  ) u_disp (
    .clk    (clk),
    .rst    (rst),
    .load_i (disp_load),
    .amt_i  (change_total_d),
    .abort_i(service_mode),
    .pulse_o(change_pulse),
    .hi_o   (change_hi),
    .busy_o (disp_busy)
  );

  assign coin_total        = credit_q;
  assign coin_reject       = coin_reject_q;
  assign product_dispensed = (state_q == ST_VEND) && !service_mode;
  assign dispensed_sel     = product_dispensed ? sel_q : '0;
  assign change_total      = change_total_q;
  assign alarm             = (state_q == ST_ALARM) && !service_mode;
  assign alarm_code        = alarm_code_q;
  assign busy              = (state_q != ST_IDLE);
  assign total_sales       = total_sales_q;

endmodule
